// File: rtl/cpu_bus_pkg.sv
// Shared types and bus widths for the cpu-style memory bus and its arbiter.
package cpu_bus_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after 'last', with wrap-around.
module rr_pick
  import cpu_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Walk the requesters starting just after the previous winner.
  always_comb begin
    int  k;
    logic hit;
    onehot = {N{1'b0}};
    idx    = {IW{1'b0}};
    valid  = 1'b0;
    k      = 0;
    hit    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k         = (int'(last) + i) % N;
      hit       = !valid && req[k];
      onehot[k] = onehot[k] | hit;
      idx       = hit ? IW'(k) : idx;
      valid     = valid | hit;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one cpu-style bus slave between NUM_MASTERS requesters,
// one transaction per grant, with an optional no-ack watchdog.
module wb_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst_n_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [DAT_W*NUM_MASTERS-1:0] m_dat_i,
  input  logic [SEL_W*NUM_MASTERS-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADR_W-1:0]             s_adr_o,
  output logic [DAT_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]             s_sel_o,
  input  logic                         s_ack_i,
  input  logic [DAT_W-1:0]             s_dat_i
);

  localparam int             IW      = idx_width(NUM_MASTERS);
  localparam int             CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic           WD_EN   = (TIMEOUT_CYCLES > 0);

  state_t                   state_r;
  state_t                   state_nxt;
  logic [NUM_MASTERS-1:0]   grant_r;
  logic [IW-1:0]            gidx_r;
  logic [IW-1:0]            last_r;
  logic [CW-1:0]            cnt_r;
  logic [NUM_MASTERS-1:0]   pick_onehot;
  logic [IW-1:0]            pick_idx;
  logic                     pick_valid;
  logic                     g_stb;
  logic                     timeout_s;

  rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req    (m_stb_i),
    .last   (last_r),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign g_stb     = m_stb_i[gidx_r];
  // An ack in the same cycle always beats the watchdog.
  assign timeout_s = WD_EN && (state_r == BUSY) && g_stb && !s_ack_i && (cnt_r == CNT_MAX);
  assign grant_o   = grant_r;
  assign m_dat_o   = s_dat_i;

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    state_nxt = (pick_valid && !s_ack_i) ? BUSY : IDLE;
      BUSY: begin
        if (!g_stb) begin
          state_nxt = s_ack_i ? DRAIN : IDLE;
        end else if (timeout_s) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = BUSY;
        end
      end
      DRAIN:   state_nxt = (!s_ack_i && !g_stb) ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      grant_r <= {NUM_MASTERS{1'b0}};
      gidx_r  <= {IW{1'b0}};
      last_r  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_r <= state_nxt;
      if (state_r == IDLE && state_nxt == BUSY) begin
        grant_r <= pick_onehot;
        gidx_r  <= pick_idx;
        last_r  <= pick_idx;
      end else if (state_nxt == IDLE) begin
        grant_r <= {NUM_MASTERS{1'b0}};
      end
    end
  end

  // Cycles spent in BUSY waiting for an ack; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r != BUSY || s_ack_i) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  always_comb begin
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = {ADR_W{1'b0}};
    s_dat_o = {DAT_W{1'b0}};
    s_sel_o = {SEL_W{1'b0}};
    m_ack_o = {NUM_MASTERS{1'b0}};
    m_err_o = {NUM_MASTERS{1'b0}};
    case (state_r)
      BUSY: begin
        s_stb_o = g_stb;
        s_we_o  = m_we_i[gidx_r];
        s_adr_o = m_adr_i[int'(gidx_r)*ADR_W +: ADR_W];
        s_dat_o = m_dat_i[int'(gidx_r)*DAT_W +: DAT_W];
        s_sel_o = m_sel_i[int'(gidx_r)*SEL_W +: SEL_W];
        m_ack_o = grant_r & {NUM_MASTERS{s_ack_i}};
        m_err_o = grant_r & {NUM_MASTERS{timeout_s}};
      end
      DRAIN:   m_ack_o = grant_r & {NUM_MASTERS{s_ack_i}};
      default: m_ack_o = {NUM_MASTERS{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: cycle tables for arbitration/handshake plus
// hand-written watchdog, ack-boundary and async-reset sequences.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [1:0]  m_stb_i, m_we_i, m_ack_o, m_err_o, grant_o;
  logic [63:0] m_adr_i, m_dat_i;
  logic [7:0]  m_sel_i;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        s_stb_o, s_we_o, s_ack_i;
  logic [3:0]  s_sel_o;

  int checks = 0;
  int errors = 0;
  int err_seen0 = 0;
  int err_seen1 = 0;

  typedef struct {
    logic [1:0]  stb;
    logic        ack;
    logic [1:0]  grant;
    logic        sstb;
    logic [1:0]  mack;
    logic [1:0]  merr;
    logic        chk_adr;
    logic [31:0] adr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  wb_bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n_i(rst_n_i),
    .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o), .grant_o(grant_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] stb, input logic ack, input logic [1:0] grant, input logic sstb,
                     input logic [1:0] mack, input logic [1:0] merr, input logic chk_adr, input logic [31:0] adr);
    vec_t v;
    v.stb = stb; v.ack = ack; v.grant = grant; v.sstb = sstb;
    v.mack = mack; v.merr = merr; v.chk_adr = chk_adr; v.adr = adr;
    vecs.push_back(v);
  endtask

  task automatic cycle(input logic [1:0] stb, input logic ack);
    @(negedge clk);
    m_stb_i = stb;
    s_ack_i = ack;
    #1;
    err_seen0 += int'(m_err_o[0]);
    err_seen1 += int'(m_err_o[1]);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      cycle(vecs[i].stb, vecs[i].ack);
      chk($sformatf("%s[%0d].grant", tag, i), {30'd0, grant_o}, {30'd0, vecs[i].grant});
      chk($sformatf("%s[%0d].s_stb", tag, i), {31'd0, s_stb_o}, {31'd0, vecs[i].sstb});
      chk($sformatf("%s[%0d].m_ack", tag, i), {30'd0, m_ack_o}, {30'd0, vecs[i].mack});
      chk($sformatf("%s[%0d].m_err", tag, i), {30'd0, m_err_o}, {30'd0, vecs[i].merr});
      if (vecs[i].chk_adr) chk($sformatf("%s[%0d].s_adr", tag, i), s_adr_o, vecs[i].adr);
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n_i = 1'b0;
    m_stb_i = 2'b00;
    s_ack_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    err_seen0 = 0;
    err_seen1 = 0;
  endtask

  initial begin
    logic [1:0]  own;
    logic [1:0]  req;
    logic [31:0] a;
    rst_n_i = 1'b0;
    m_stb_i = 2'b00;
    s_ack_i = 1'b0;
    m_we_i  = 2'b10;
    m_adr_i = {32'h0000_0200, 32'h0000_0100};
    m_dat_i = {32'h0000_1234, 32'hCAFE_0000};
    m_sel_i = {4'h3, 4'hF};
    s_dat_i = 32'hDEAD_BEEF;
    #12;
    chk("rst.grant", {30'd0, grant_o}, 32'd0);
    chk("rst.s_stb", {31'd0, s_stb_o}, 32'd0);
    chk("rst.s_we", {31'd0, s_we_o}, 32'd0);
    chk("rst.s_adr", s_adr_o, 32'd0);
    chk("rst.s_dat", s_dat_o, 32'd0);
    chk("rst.s_sel", {28'd0, s_sel_o}, 32'd0);
    chk("rst.m_ack", {30'd0, m_ack_o}, 32'd0);
    chk("rst.m_err", {30'd0, m_err_o}, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;

    // single master read, ack after three BUSY cycles
    add(2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
    add(2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
    add(2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 32'h100);
    add(2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 32'h100);
    add(2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 32'h100);
    add(2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 32'h100);
    add(2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 32'h100);
    add(2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
    run_vecs("single");
    chk("single.m_dat", m_dat_o, 32'hDEAD_BEEF);

    // contention: four transfers each, alternating, idle cycle between grants
    do_reset();
    for (int t = 0; t < 8; t++) begin
      own = (t % 2 == 0) ? 2'b01 : 2'b10;
      a   = (t % 2 == 0) ? 32'h100 : 32'h200;
      req = (t < 7) ? 2'b11 : own;
      add(req,        1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
      add(req,        1'b0, own,   1'b1, 2'b00, 2'b00, 1'b1, a);
      add(req,        1'b1, own,   1'b1, own,   2'b00, 1'b1, a);
      add(req & ~own, 1'b0, own,   1'b0, 2'b00, 2'b00, 1'b1, a);
    end
    add(2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
    run_vecs("contend");

    // stale ack held two cycles after master0 drops stb; master1 waiting
    do_reset();
    add(2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
    add(2'b11, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 32'h100);
    add(2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 32'h100);
    add(2'b10, 1'b1, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 32'h100);
    add(2'b10, 1'b1, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 32'h0);
    add(2'b10, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    add(2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
    add(2'b10, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 32'h200);
    add(2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00, 1'b1, 32'h200);
    add(2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 32'h200);
    add(2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
    run_vecs("stale");

    // watchdog: master1 write never acked
    do_reset();
    cycle(2'b10, 1'b0);
    chk("to.idle_grant", {30'd0, grant_o}, 32'd0);
    cycle(2'b10, 1'b0);
    chk("to.grant", {30'd0, grant_o}, 32'h2);
    chk("to.s_we", {31'd0, s_we_o}, 32'd1);
    chk("to.s_sel", {28'd0, s_sel_o}, 32'h3);
    chk("to.s_dat", s_dat_o, 32'h1234);
    chk("to.s_adr", s_adr_o, 32'h200);
    for (int k = 2; k <= 9; k++) begin
      cycle(2'b10, 1'b0);
      chk($sformatf("to.busy%0d.m_err", k), {30'd0, m_err_o}, (k == 9) ? 32'h2 : 32'h0);
      chk($sformatf("to.busy%0d.s_stb", k), {31'd0, s_stb_o}, 32'd1);
    end
    cycle(2'b10, 1'b0);
    chk("to.drain.s_stb", {31'd0, s_stb_o}, 32'd0);
    chk("to.drain.grant", {30'd0, grant_o}, 32'h2);
    chk("to.drain.m_err", {30'd0, m_err_o}, 32'd0);
    cycle(2'b10, 1'b0);
    chk("to.drain2.s_stb", {31'd0, s_stb_o}, 32'd0);
    cycle(2'b01, 1'b0);
    chk("to.exit.grant", {30'd0, grant_o}, 32'h2);
    cycle(2'b01, 1'b0);
    chk("to.idle2.grant", {30'd0, grant_o}, 32'd0);
    cycle(2'b01, 1'b0);
    chk("to.m0.grant", {30'd0, grant_o}, 32'h1);
    chk("to.m0.s_adr", s_adr_o, 32'h100);
    cycle(2'b01, 1'b1);
    chk("to.m0.m_ack", {30'd0, m_ack_o}, 32'h1);
    cycle(2'b00, 1'b0);
    chk("to.err1_pulses", err_seen1, 32'd1);
    chk("to.err0_pulses", err_seen0, 32'd0);

    // ack arrives the same cycle the counter reaches the limit
    do_reset();
    cycle(2'b01, 1'b0);
    for (int k = 1; k <= 8; k++) cycle(2'b01, 1'b0);
    chk("bnd.grant", {30'd0, grant_o}, 32'h1);
    cycle(2'b01, 1'b1);
    chk("bnd.m_ack", {30'd0, m_ack_o}, 32'h1);
    chk("bnd.m_err", {30'd0, m_err_o}, 32'd0);
    cycle(2'b00, 1'b0);
    chk("bnd.drop.s_stb", {31'd0, s_stb_o}, 32'd0);
    cycle(2'b00, 1'b0);
    chk("bnd.idle.grant", {30'd0, grant_o}, 32'd0);
    chk("bnd.err_pulses", err_seen0 + err_seen1, 32'd0);

    // asynchronous reset in the middle of a transfer
    do_reset();
    cycle(2'b01, 1'b0);
    cycle(2'b01, 1'b1);
    chk("arst.pre.grant", {30'd0, grant_o}, 32'h1);
    chk("arst.pre.m_ack", {30'd0, m_ack_o}, 32'h1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst.grant", {30'd0, grant_o}, 32'd0);
    chk("arst.s_stb", {31'd0, s_stb_o}, 32'd0);
    chk("arst.m_ack", {30'd0, m_ack_o}, 32'd0);
    @(negedge clk);
    m_stb_i = 2'b11;
    s_ack_i = 1'b0;
    rst_n_i = 1'b1;
    #1;
    chk("arst.rel.grant", {30'd0, grant_o}, 32'd0);
    cycle(2'b11, 1'b0);
    chk("arst.first.grant", {30'd0, grant_o}, 32'h1);
    chk("arst.first.s_stb", {31'd0, s_stb_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
